// File: rtl/clause_class_sum_if.sv
// rtl/clause_class_sum_if.sv - clause stream, weight write and prediction handshake bundle
interface clause_class_sum_if #(
    parameter int CLAUSEN      = 10,
    parameter int CLASSN       = 5,
    parameter int WEIGHT_WIDTH = 8,
    parameter int SUM_WIDTH    = 16
) ();
    logic                         img_start;
    logic                         clause_valid;
    logic                         clause_op;
    logic                         w_wr;
    logic [$clog2(CLASSN)-1:0]    w_class;
    logic [$clog2(CLAUSEN)-1:0]   w_clause;
    logic [WEIGHT_WIDTH-1:0]      w_data;
    logic                         pred_valid;
    logic                         pred_ready;
    logic [$clog2(CLASSN)-1:0]    pred_class;
    logic [SUM_WIDTH-1:0]         pred_sum;
    logic                         busy;

    modport master (
        output img_start, clause_valid, clause_op, w_wr, w_class, w_clause, w_data, pred_ready,
        input  pred_valid, pred_class, pred_sum, busy
    );

    modport slave (
        input  img_start, clause_valid, clause_op, w_wr, w_class, w_clause, w_data, pred_ready,
        output pred_valid, pred_class, pred_sum, busy
    );
endinterface

// File: rtl/clause_class_sum.sv
// rtl/clause_class_sum.sv - per-class weighted clause vote accumulation and sequential argmax
// Optional clamping of class sums is enabled by defining CLASS_SUM_SATURATE_EN.
module clause_class_sum #(
    parameter int CLAUSEN      = 10,
    parameter int CLASSN       = 5,
    parameter int WEIGHT_WIDTH = 8,
    parameter int SUM_WIDTH    = 16
) (
    input logic               clk,
    input logic               rst,
    clause_class_sum_if.slave bus
);
    localparam int CW = $clog2(CLASSN);
    localparam int IW = $clog2(CLAUSEN);
    localparam logic [IW-1:0] LAST_CLAUSE = IW'(CLAUSEN - 1);
    localparam logic [CW-1:0] LAST_CLASS  = CW'(CLASSN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, HOLD} state_t;

    state_t                        state, state_next;
    logic signed [WEIGHT_WIDTH-1:0] weights [CLASSN][CLAUSEN];
    logic signed [SUM_WIDTH-1:0]    sums [CLASSN];
    logic [IW-1:0]                  clause_idx;
    logic [CW-1:0]                  k;
    logic signed [SUM_WIDTH-1:0]    best;
    logic [CW-1:0]                  best_idx;

    function automatic logic signed [SUM_WIDTH-1:0] acc_add(
        input logic signed [SUM_WIDTH-1:0] a,
        input logic signed [SUM_WIDTH-1:0] b
    );
        logic signed [SUM_WIDTH-1:0] r;
        r = a + b;
`ifdef CLASS_SUM_SATURATE_EN
        // Same-sign operands producing an opposite-sign result means overflow.
        if (a[SUM_WIDTH-1] == b[SUM_WIDTH-1] && r[SUM_WIDTH-1] != a[SUM_WIDTH-1])
            r = a[SUM_WIDTH-1] ? {1'b1, {(SUM_WIDTH-1){1'b0}}} : {1'b0, {(SUM_WIDTH-1){1'b1}}};
`endif
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (bus.img_start) begin
            state_next = ACCUM;
        end else begin
            case (state)
                IDLE:   state_next = IDLE;
                ACCUM:  if (bus.clause_valid && clause_idx == LAST_CLAUSE) state_next = ARGMAX;
                ARGMAX: if (k == LAST_CLASS) state_next = HOLD;
                HOLD:   if (bus.pred_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CLASSN; c++) begin
                sums[c] <= '0;
                for (int j = 0; j < CLAUSEN; j++) weights[c][j] <= '0;
            end
            clause_idx <= '0;
            k          <= '0;
            best       <= '0;
            best_idx   <= '0;
        end else begin
            if (bus.w_wr && int'(bus.w_class) < CLASSN && int'(bus.w_clause) < CLAUSEN)
                weights[bus.w_class][bus.w_clause] <= bus.w_data;

            // A start in any state wins over a coincident clause strobe.
            if (bus.img_start) begin
                for (int c = 0; c < CLASSN; c++) sums[c] <= '0;
                clause_idx <= '0;
                k          <= '0;
            end else begin
                case (state)
                    ACCUM: begin
                        k <= '0;
                        if (bus.clause_valid) begin
                            if (bus.clause_op)
                                for (int c = 0; c < CLASSN; c++)
                                    sums[c] <= acc_add(sums[c], SUM_WIDTH'(weights[c][clause_idx]));
                            clause_idx <= clause_idx + 1'b1;
                        end
                    end
                    ARGMAX: begin
                        if (k == '0) begin
                            best     <= sums[0];
                            best_idx <= '0;
                        end else if (sums[k] > best) begin
                            best     <= sums[k];
                            best_idx <= k;
                        end
                        k <= k + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.pred_valid = (state == HOLD);
    assign bus.pred_class = best_idx;
    assign bus.pred_sum   = best;
    assign bus.busy       = (state == ACCUM) || (state == ARGMAX);
endmodule

// File: tb/tb_clause_class_sum.sv
// tb/tb_clause_class_sum.sv - directed checks of accumulation, argmax, abort, handshake and overflow
module tb_clause_class_sum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clause_class_sum_if #(.CLAUSEN(10), .CLASSN(5), .WEIGHT_WIDTH(8), .SUM_WIDTH(16)) bus ();
    clause_class_sum_if #(.CLAUSEN(10), .CLASSN(5), .WEIGHT_WIDTH(8), .SUM_WIDTH(8))  bus8 ();

    clause_class_sum #(.CLAUSEN(10), .CLASSN(5), .WEIGHT_WIDTH(8), .SUM_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    clause_class_sum #(.CLAUSEN(10), .CLASSN(5), .WEIGHT_WIDTH(8), .SUM_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8)
    );

    assign bus8.img_start    = bus.img_start;
    assign bus8.clause_valid = bus.clause_valid;
    assign bus8.clause_op    = bus.clause_op;
    assign bus8.w_wr         = bus.w_wr;
    assign bus8.w_class      = bus.w_class;
    assign bus8.w_clause     = bus.w_clause;
    assign bus8.w_data       = bus.w_data;
    assign bus8.pred_ready   = bus.pred_ready;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int c, input int j, input int d);
        bus.w_wr     = 1'b1;
        bus.w_class  = 3'(c);
        bus.w_clause = 4'(j);
        bus.w_data   = 8'(d);
        cyc();
        bus.w_wr     = 1'b0;
    endtask

    // mode 0: c+1, 1: all 3, 2: class 2 = -1 else -5, 3: all 127
    task automatic load_weights(input int mode);
        int d;
        for (int c = 0; c < 5; c++)
            for (int j = 0; j < 10; j++) begin
                case (mode)
                    0: d = c + 1;
                    1: d = 3;
                    2: d = (c == 2) ? -1 : -5;
                    default: d = 127;
                endcase
                wr(c, j, d);
            end
    endtask

    task automatic start();
        bus.img_start = 1'b1;
        cyc();
        bus.img_start = 1'b0;
    endtask

    task automatic strobe(input logic op);
        bus.clause_valid = 1'b1;
        bus.clause_op    = op;
        cyc();
        bus.clause_valid = 1'b0;
        bus.clause_op    = 1'b0;
    endtask

    task automatic run_image(input logic [9:0] ops);
        start();
        for (int j = 0; j < 10; j++) strobe(ops[j]);
    endtask

    task automatic wait_pred(input string tag, input int exp_lat);
        int lat = 0;
        while (!bus.pred_valid && lat < 50) begin
            cyc();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic accept();
        bus.pred_ready = 1'b1;
        cyc();
        bus.pred_ready = 1'b0;
    endtask

    initial begin
        bus.img_start = 0; bus.clause_valid = 0; bus.clause_op = 0;
        bus.w_wr = 0; bus.w_class = 0; bus.w_clause = 0; bus.w_data = 0; bus.pred_ready = 0;
        repeat (3) cyc();
        check("rst_pred_valid", bus.pred_valid, 0);
        check("rst_pred_class", bus.pred_class, 0);
        check("rst_pred_sum", bus.pred_sum, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        cyc();

        // Ranking
        load_weights(0);
        run_image(10'h3ff);
        for (int c = 0; c < 5; c++) check($sformatf("rank_sum%0d", c), $signed(dut.sums[c]), (c + 1) * 10);
        check("rank_busy_argmax", bus.busy, 1);
        wait_pred("rank", 5);
        check("rank_class", bus.pred_class, 4);
        check("rank_sum", $signed(bus.pred_sum), 50);
        check("rank_busy_hold", bus.busy, 0);
        accept();
        check("rank_accepted", bus.pred_valid, 0);

        // Tie and masking, with a held-off consumer
        load_weights(1);
        run_image(10'b00000_11111);
        wait_pred("tie", 5);
        for (int i = 0; i < 7; i++) begin
            check("tie_hold_valid", bus.pred_valid, 1);
            check("tie_hold_class", bus.pred_class, 0);
            check("tie_hold_sum", $signed(bus.pred_sum), 15);
            cyc();
        end
        accept();
        check("tie_accepted", bus.pred_valid, 0);
        bus.pred_ready = 1'b1;
        repeat (2) cyc();
        check("tie_single_accept", bus.pred_valid, 0);
        check("tie_idle_busy", bus.busy, 0);

        // Negative weights, ready tied high gives one-cycle pulse
        load_weights(2);
        run_image(10'h3ff);
        wait_pred("neg", 5);
        check("neg_class", bus.pred_class, 2);
        check("neg_sum", $signed(bus.pred_sum), -10);
        cyc();
        check("neg_pulse", bus.pred_valid, 0);
        bus.pred_ready = 1'b0;

        // Abort, then start coinciding with a clause strobe
        load_weights(0);
        start();
        for (int j = 0; j < 4; j++) strobe(1'b1);
        check("abort_pre_sum4", $signed(dut.sums[4]), 20);
        bus.img_start = 1'b1; bus.clause_valid = 1'b1; bus.clause_op = 1'b1;
        cyc();
        bus.img_start = 1'b0; bus.clause_valid = 1'b0; bus.clause_op = 1'b0;
        check("abort_dropped_sum0", $signed(dut.sums[0]), 0);
        check("abort_busy", bus.busy, 1);
        for (int j = 0; j < 10; j++) strobe((j % 2) == 0);
        for (int c = 0; c < 5; c++) check($sformatf("abort_sum%0d", c), $signed(dut.sums[c]), (c + 1) * 5);
        wait_pred("abort", 5);
        check("abort_class", bus.pred_class, 4);
        check("abort_sum", $signed(bus.pred_sum), 25);
        accept();

        // Reset mid-accumulation
        start();
        for (int j = 0; j < 3; j++) strobe(1'b1);
        rst = 1'b1;
        cyc();
        check("midrst_pred_valid", bus.pred_valid, 0);
        check("midrst_pred_class", bus.pred_class, 0);
        check("midrst_pred_sum", bus.pred_sum, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_sum4", $signed(dut.sums[4]), 0);
        rst = 1'b0;
        cyc();

        // Overflow in the narrow instance
        load_weights(3);
        run_image(10'h3ff);
        wait_pred("ovf", 5);
        check("ovf_wide_class", bus.pred_class, 0);
        check("ovf_wide_sum", $signed(bus.pred_sum), 1270);
        check("ovf_narrow_valid", bus8.pred_valid, 1);
        check("ovf_narrow_class", bus8.pred_class, 0);
`ifdef CLASS_SUM_SATURATE_EN
        check("ovf_narrow_sum", $signed(bus8.pred_sum), 127);
`else
        check("ovf_narrow_sum", $signed(bus8.pred_sum), -10);
`endif
        accept();
        check("ovf_accepted", bus8.pred_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
